// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: Set-2 scan-code constants, frame and
// decode state encodings, and the odd-parity helper.
package ps2_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_e;

  typedef enum logic [1:0] {
    DEC_NORMAL    = 2'd0,
    DEC_EXT       = 2'd1,
    DEC_BREAK     = 2'd2,
    DEC_EXT_BREAK = 2'd3
  } dec_state_e;

  // True when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, optional ps2_clk glitch filter
// (PS2_GLITCH_FILTER_EN), 11-bit frame FSM and mid-frame timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic [7:0]   byte_data_o,
  output logic         byte_valid_o,
  output logic         frame_err_o,
  output logic         byte_strobe_o,
  output logic [7:0]   byte_next_o,
  output frame_state_e state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_GLITCH_FILTER_EN
  localparam bit FiltEn = 1'b1;
`else
  localparam bit FiltEn = 1'b0;
`endif

  logic clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic clk_lvl, clk_prev_q, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data_i;
      data_s2_q <= data_s1_q;
    end
  end

  // The filtered level follows the pin only after FILTER_CYCLES agreeing samples.
  if (FiltEn && FILTER_CYCLES > 0) begin : g_filt
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    logic [FW-1:0] fcnt_q;
    logic          filt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fcnt_q <= '0;
        filt_q <= 1'b1;
      end else if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
        fcnt_q <= '0;
        filt_q <= clk_s2_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
    assign clk_lvl = filt_q;
  end else begin : g_nofilt
    assign clk_lvl = clk_s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_prev_q <= 1'b1;
    else     clk_prev_q <= clk_lvl;
  end

  assign fall = clk_prev_q & ~clk_lvl;

  frame_state_e  state_q, state_d;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          timeout;
  logic          shift_en, par_en, stop_ev, good, bad;

  assign timeout = (state_q != FR_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FR_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = FR_IDLE;
    end else if (fall) begin
      unique case (state_q)
        FR_IDLE:   if (!data_s2_q) state_d = FR_DATA;
        FR_DATA:   if (bitcnt_q == 3'd7) state_d = FR_PARITY;
        FR_PARITY: state_d = FR_STOP;
        FR_STOP:   state_d = FR_IDLE;
        default:   state_d = FR_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_ev  = 1'b0;
    unique case (state_q)
      FR_DATA:   shift_en = fall;
      FR_PARITY: par_en   = fall;
      FR_STOP:   stop_ev  = fall;
      default:   ;
    endcase
    good = stop_ev && data_s2_q && odd_parity_ok(shift_q, par_q);
    bad  = (stop_ev && !good) || timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      byte_data_o  <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      if (state_q == FR_IDLE) bitcnt_q <= '0;
      else if (shift_en)      bitcnt_q <= bitcnt_q + 1'b1;
      if (shift_en) shift_q <= {data_s2_q, shift_q[7:1]};
      if (par_en)   par_q   <= data_s2_q;
      if (state_q == FR_IDLE || fall)       tmo_q <= '0;
      else if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + 1'b1;
      if (good) byte_data_o <= shift_q;
      byte_valid_o <= good;
      frame_err_o  <= bad;
    end
  end

  // The strobe lets the decoder register its result alongside byte_valid.
  assign byte_strobe_o = good;
  assign byte_next_o   = shift_q;
  assign state_o       = state_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 keycode receiver: frame reception plus make/break/E0 decoding
// into a held keycode. Optional PS2_GLITCH_FILTER_EN filters ps2_clk.
// byte_valid is a one-cycle strobe with no ready; byte_data must be taken then.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_ext,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  logic         strobe;
  logic [7:0]   nbyte;
  frame_state_e frame_state;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_CYCLES  (FILTER_CYCLES)
  ) u_frame (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .byte_data_o   (byte_data),
    .byte_valid_o  (byte_valid),
    .frame_err_o   (frame_err),
    .byte_strobe_o (strobe),
    .byte_next_o   (nbyte),
    .state_o       (frame_state)
  );

  dec_state_e dec_q, dec_d;
  logic [7:0] key_q;
  logic       ext_q;
  logic       make_en, make_ext, brk_en, brk_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_q <= DEC_NORMAL;
    else     dec_q <= dec_d;
  end

  always_comb begin
    dec_d = dec_q;
    if (strobe) begin
      unique case (dec_q)
        DEC_NORMAL: begin
          if (nbyte == PFX_EXT)        dec_d = DEC_EXT;
          else if (nbyte == PFX_BREAK) dec_d = DEC_BREAK;
        end
        DEC_EXT: dec_d = (nbyte == PFX_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
        default: dec_d = DEC_NORMAL;
      endcase
    end
  end

  // In a break state every byte is the code itself, prefixes included.
  always_comb begin
    make_en  = 1'b0;
    make_ext = 1'b0;
    brk_en   = 1'b0;
    brk_ext  = 1'b0;
    if (strobe) begin
      unique case (dec_q)
        DEC_NORMAL:    make_en = (nbyte != PFX_EXT) && (nbyte != PFX_BREAK);
        DEC_EXT: begin
          make_en  = (nbyte != PFX_BREAK);
          make_ext = 1'b1;
        end
        DEC_BREAK:     brk_en = 1'b1;
        DEC_EXT_BREAK: begin
          brk_en  = 1'b1;
          brk_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      ext_q <= 1'b0;
    end else if (make_en) begin
      key_q <= nbyte;
      ext_q <= make_ext;
    end else if (brk_en && (nbyte == key_q) && (brk_ext == ext_q)) begin
      key_q <= '0;
      ext_q <= 1'b0;
    end
  end

  assign keycode = key_q;
  assign key_ext = ext_q;

endmodule
